// File: rtl/out_serializer_pkg.sv
// Shared types for the output serializer: TX FSM state encoding and frame-length helper.
package out_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Cycles occupied by one frame: start bit, data bits, stop bit.
    function automatic int unsigned frame_cycles(input int unsigned bit_width,
                                                 input int unsigned clks_per_bit);
        return (bit_width + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign level   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/out_serializer.sv
// Captures every change on the processor output word into a FIFO and sends each
// buffered word as a start/data(LSB first)/stop serial frame on tx.
module out_serializer
    import out_serializer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH    = 4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_WIDTH-1:0]          din,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BI = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    logic [BIT_WIDTH-1:0] last_din_q, last_din_d;
    logic                 overflow_q, overflow_d;
    tx_state_e            state_q;
    logic [CW-1:0]        baud_q;
    logic [BI-1:0]        bit_q;
    logic [BIT_WIDTH-1:0] shift_q;
    logic [BIT_WIDTH-1:0] shift_nx;
    logic                 tx_q;
    logic                 busy_q;

    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BIT_WIDTH-1:0] fifo_dout;
    logic                 baud_last;
    logic                 bit_last;

    assign push_req   = (din != last_din_q);
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign last_din_d = din;
    // A full FIFO still takes the word when the FSM pops on the same edge.
    assign overflow_d = overflow_q | (push_req && fifo_full && !pop);
    assign baud_last  = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign bit_last   = (bit_q == BI'(BIT_WIDTH - 1));
    assign shift_nx   = shift_q >> 1;

    sync_fifo #(
        .WIDTH (BIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_din_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            last_din_q <= last_din_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_dout;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_last) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_nx;
                            tx_q    <= shift_nx[0];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_out_serializer.sv
// Self-checking bench for out_serializer: frame-level reference model plus a tx line decoder.
module tb_out_serializer;
    import out_serializer_pkg::*;

    localparam int unsigned BW    = 4;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FL    = frame_cycles(BW, CPB);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [BW-1:0]             din = '0;
    logic                      tx;
    logic                      busy;
    logic                      overflow;
    logic [$clog2(DEPTH):0]    level;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    out_serializer #(
        .BIT_WIDTH    (BW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    // Reference model: a queue of pending words and a frame timer.
    bit [BW-1:0] m_q[$];
    bit          m_active;
    int unsigned m_t;
    bit [BW-1:0] m_word;
    bit [BW-1:0] m_last;
    bit          m_ovf;
    bit          m_pop;
    int unsigned m_sz;
    bit [BW-1:0] m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_last   = '0;
            m_ovf    = 1'b0;
        end else begin
            m_sz  = m_q.size();
            m_pop = !m_active && (m_sz > 0);
            if (m_pop) m_w = m_q.pop_front();
            if (din != m_last) begin
                if (m_sz < DEPTH || m_pop) m_q.push_back(din);
                else m_ovf = 1'b1;
                m_last = din;
            end
            if (m_active) begin
                m_t++;
                if (m_t == FL) m_active = 1'b0;
            end
            if (m_pop) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = m_w;
            end
        end
    end

    function automatic logic exp_tx();
        int unsigned k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= BW) return m_word[k-1];
        return 1'b1;
    endfunction

    // Line decoder: samples mid-bit once busy is seen, collects whole frames.
    logic [BW-1:0] dec_q[$];
    bit            d_in;
    int unsigned   d_c;
    int unsigned   d_k;
    logic [BW-1:0] d_word;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            d_in = 1'b0;
        end else begin
            if (!d_in && busy === 1'b1) begin
                d_in = 1'b1;
                d_c  = 0;
            end
            if (d_in) begin
                d_k = d_c / CPB;
                if ((d_c % CPB) == CPB / 2 && d_k >= 1 && d_k <= BW) d_word[d_k-1] = tx;
                d_c++;
                if (d_c == FL) begin
                    dec_q.push_back(d_word);
                    d_in = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("level", 32'(level), 32'(m_q.size()));
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((busy !== 1'b0 || level !== '0) && i < budget) begin
            cycle();
            i++;
        end
        chk("drain_idle", {31'd0, busy} | 32'(level), 32'd0);
        run(2);
    endtask

    int bc;
    int exp_fib[6] = '{1, 2, 3, 5, 8, 13};
    int fib_in[7]  = '{1, 1, 2, 3, 5, 8, 13};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        din = '0;
        run(3);
        rst = 1'b0;
        run(40);
        chk("reset_no_frame", 32'(dec_q.size()), 32'd0);

        din = 4'd5;
        bc  = 0;
        repeat (60) begin
            cycle();
            if (busy === 1'b1) bc++;
        end
        chk("busy_len", 32'(bc), 32'(FL));
        chk("hold_frames", 32'(dec_q.size()), 32'd1);
        chk("frame_5", 32'(dec_q[0]), 32'd5);

        dec_q.delete();
        for (int v = 1; v <= 6; v++) begin
            din = BW'(v);
            cycle();
            if (v == 5) chk("level_peak", 32'(level), 32'd4);
        end
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        wait_idle(300);
        chk("burst_frames", 32'(dec_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("burst_word", 32'(dec_q[i]), 32'(i + 1));

        dec_q.delete();
        din = 4'd6;
        run(12);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        run(2);
        rst = 1'b0;
        run(3);
        wait_idle(200);
        chk("rst_frames", 32'(dec_q.size()), 32'd1);
        chk("rst_word", 32'(dec_q[0]), 32'd6);
        chk("rst_ovf_clear", {31'd0, overflow}, 32'd0);

        repeat (400) begin
            if ($urandom_range(0, 3) == 0) din = BW'($urandom_range(0, 15));
            cycle();
        end
        wait_idle(400);

        din = '0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        dec_q.delete();
        for (int i = 0; i < 7; i++) begin
            din = BW'(fib_in[i]);
            run(FL + 2);
        end
        wait_idle(200);
        chk("fib_frames", 32'(dec_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("fib_word", 32'(dec_q[i]), 32'(exp_fib[i]));
        chk("fib_overflow", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/out_serializer.md
# out_serializer

Downstream consumer of the processor's `out` port. Detects every change on the processor output word, buffers it in a small FIFO, and transmits each buffered value as an asynchronous serial frame (start bit, BIT_WIDTH data bits LSB first, stop bit) on a single `tx` line. The block sits between `top`'s `out` bus and the board pin or bench monitor, so program results can be observed without a parallel bus.

## Interface
- `BIT_WIDTH`, 4, width of the processor output word and of the frame's data field
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; must be ≥ 1
- `FIFO_DEPTH`, 4, buffered words; power of two, ≥ 2
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset, asynchronous and active-high
- `din`  input  BIT_WIDTH  processor output word (`top.out`)
- `tx`  output  1  serial line; idle high
- `busy`  output  1  high while a frame is being shifted out
- `overflow`  output  1  sticky: a change was dropped because the FIFO was full
- `level`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `level`=0, FIFO empty, FSM in IDLE, last-captured register `last_din`=0.
- Change detect: at each edge where `din != last_din`, push `din` and set `last_din <= din`. Equal consecutive values produce one push only.
- FIFO full on a push with no simultaneous pop: word dropped, `overflow` set, `last_din` still updated. `overflow` clears only on reset.
- Push and pop on the same edge while full: both take effect, and the push is accepted.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, then go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right. After BIT_WIDTH bits, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- `busy` = (state != IDLE).
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous), the frame is abandoned and the FIFO is flushed. After release, if `din` ≠ 0 it is pushed at the first edge.

## Timing
- `tx` is driven directly from a flop, with no combinational path from `din`.
- `din` change sampled at edge E: `level` increments after E. The pop happens at edge E+1, and `tx` falls after E+1. Latency from change to start bit: 2 edges.
- Frame length is (BIT_WIDTH+2)·CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly one IDLE cycle with `tx`=1.
- Bit counter and baud counter are sized for their maxima. No wrap-around beyond BIT_WIDTH−1 or CLKS_PER_BIT−1.
- FIFO pointers wrap modulo FIFO_DEPTH. `level` ranges 0..FIFO_DEPTH.

## Structure
- Shared package: FSM state encoding (IDLE/START/DATA/STOP as a 2-bit localparam set) and the frame-length helper constant.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports push/pop/din/dout/full/empty/level), reusable elsewhere in the design.
- Change detect and TX FSM live in `out_serializer` itself.

## Test plan
- Reset with `din`=0 held for 40 cycles -> `tx`=1, `busy`=0, `level`=0, `overflow`=0 throughout, and no frame.
- `din` 0→5 -> `tx` low 4 cycles, then 1,0,1,0 at 4 cycles each, then high 4 cycles. Total 24 cycles; `busy` high for exactly 24 cycles.
- `din` held at 5 for 60 cycles after the change -> exactly one frame.
- `din` = 1,2,3,4,5,6 on six consecutive edges while idle -> `level` peaks at 4 and `overflow`=1 after the 6th edge. Frames 1,2,3,4,5 are sent in order; 6 is never sent.
- `rst` pulsed during the DATA state with `din`=6 held -> `tx`=1 immediately, `level`=0. After release, exactly one frame carrying 6.
- Driven by `top` running the Fibonacci ROM -> decoded frames are 1,2,3,5,8,13,… The repeated 1 collapses to a single frame, and `overflow` stays 0 with CLKS_PER_BIT=1.
